// File: rtl/serial_subtractor_if.sv
// Request/response bundle for the bit-serial subtractor.
// The requester drives operands and start; the subtractor returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] data_A;
  logic [WIDTH-1:0] data_B;
  logic             borrow_in;
  logic             busy;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             done;

  modport master (
    output start, data_A, data_B, borrow_in,
    input  ready, busy, diff, borrow_out, overflow, done
  );

  modport slave (
    input  start, data_A, data_B, borrow_in,
    output ready, busy, diff, borrow_out, overflow, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = data_A - data_B - borrow_in,
// one bit per clock, LSB first, with a single registered borrow stage.
// A request takes WIDTH cycles in RUN plus one DONE cycle that pulses done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             sign_a;
  logic             sign_b;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             overflow_q;

  logic             ready_c;
  logic             busy_c;
  logic             done_c;

  logic             accept;
  logic             last_bit;
  logic             d_bit;
  logic             nb_bit;

  // One full-subtractor cell applied to the current LSBs of the operands.
  assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
  assign nb_bit   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  assign accept   = (state == IDLE) && bus.start;
  assign last_bit = (state == RUN) && (cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  // Next-state and status decode; start is only honoured in IDLE.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    ready_c   = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial datapath, and result registers loaded on the last bit
  // so they are already valid during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.data_A;
      b_sr   <= bus.data_B;
      br     <= bus.borrow_in;
      cnt    <= '0;
      sign_a <= bus.data_A[WIDTH-1];
      sign_b <= bus.data_B[WIDTH-1];
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      br     <= nb_bit;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        // d_bit is the result MSB on the final step.
        diff_q     <= {d_bit, res_sr[WIDTH-1:1]};
        borrow_q   <= nb_bit;
        overflow_q <= (sign_a != sign_b) && (d_bit != sign_a);
      end
    end
  end

  assign bus.ready      = ready_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes data_A - data_B - borrow_in one bit per clock, LSB first.
- Uses a single registered borrow stage.
- Counterpart to the ripple adder datapath; shares its operand naming.
- Used where area matters more than latency. Sits behind a start/ready handshake and reports completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when start && ready at a rising edge
- ready  output  1  high only in IDLE; block can accept a new request
- data_A  input  WIDTH  minuend; sampled on accept only
- data_B  input  WIDTH  subtrahend; sampled on accept only
- borrow_in  input  1  initial borrow; sampled on accept only
- busy  output  1  high in RUN and DONE
- diff  output  WIDTH  result A - B - borrow_in (mod 2^WIDTH)
- borrow_out  output  1  final borrow; 1 when the unsigned result is negative
- overflow  output  1  signed overflow of the subtraction
- done  output  1  one-cycle pulse; diff, borrow_out and overflow are valid

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ready=1, busy=0, done=0, diff=0, borrow_out=0, overflow=0, bit counter=0, internal operand shift registers=0. Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1: load a_sr=data_A, b_sr=data_B, br=borrow_in, cnt=0, and latch the sign bits sA=data_A[WIDTH-1], sB=data_B[WIDTH-1]. Go to RUN.
  - diff, borrow_out and overflow keep their previous values until the next DONE.
- RUN (exactly WIDTH cycles):
  - Per cycle: d = a_sr[0] ^ b_sr[0] ^ br.
  - nb = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - Shift d into the MSB of the result shift register (shift right).
  - Shift a_sr and b_sr right by 1; br <= nb; cnt++.
  - When cnt==WIDTH-1, go to DONE after this update.
  - ready=0 throughout; start is ignored.
- DONE (one cycle):
  - done=1.
  - diff = full result register; borrow_out = br.
  - overflow = (sA != sB) && (diff[WIDTH-1] != sA).
  - Outputs are registered, so they are valid in the same cycle done is high.
  - ready=0; start is ignored. Next state: IDLE.
- Latency: accept edge at cycle 0; done high in cycle WIDTH+1. The next accept is possible at cycle WIDTH+2, giving a throughput of one op per WIDTH+2 cycles.
- Operand inputs may change freely after accept without affecting the result.
- Wrap-around: the result is modulo 2^WIDTH. Borrow out of the MSB appears only on borrow_out, never in diff.
- borrow_in applies at bit 0 only.
- Simultaneous events:
  - start held high continuously gives back-to-back operations, each accepted in IDLE.
  - Reset asserted in the same cycle as start: reset wins.
- done is never asserted in two consecutive cycles.

Test Plan:
- WIDTH=8, A=0x50, B=0x30, borrow_in=0 -> done exactly 9 cycles after the accept edge; diff=0x20, borrow_out=0, overflow=0; ready returns high the cycle after done.
- A=0x00, B=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1, overflow=0. A=0x80, B=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
- A=0x10, B=0x0F, borrow_in=1 -> diff=0x00, borrow_out=0. A=0x00, B=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1.
- Accept A=0x05, B=0x03; during RUN pulse start with A=0xAA, B=0x11 and change data_A/data_B every cycle -> single done, diff=0x02; second request not captured.
- start held high with operand pairs (0x09,0x04) then (0x7F,0xFF) -> done pulses at cycles 9 and 19 (10 cycles apart); diff=0x05, then 0x80 with borrow_out=1 and overflow=1.
- Assert rst_n low at cycle 4 of RUN -> outputs clear immediately, ready=1, no done pulse. A new request A=0x33, B=0x11 completes normally with diff=0x22.
